// File: rtl/irq_dispatch_pkg.sv
// Shared types and default timing constants for the interrupt dispatch controller.
package irq_dispatch_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      CLEAR   = 2'd2,
      HOLDOFF = 2'd3
   } dispatch_state_e;

   localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1024;
   localparam int unsigned DEFAULT_HOLDOFF_CYCLES = 2;

endpackage

// File: rtl/irq_dispatch_ctrl_rr_find_first.sv
// Round-robin search: lowest set pending bit at or above rr_ptr, wrapping to bit 0.
module rr_find_first
   import irq_dispatch_pkg::*;
#(
   parameter int unsigned NUM_LINES = 32,
   parameter int unsigned ID_W      = $clog2(NUM_LINES)
) (
   input  logic [NUM_LINES-1:0] pending,
   input  logic [ID_W-1:0]      rr_ptr,
   output logic                 valid,
   output logic [ID_W-1:0]      id
);

   int unsigned idx;

   // Walk offsets from farthest to nearest so the nearest hit is the one kept.
   always_comb begin
      valid = 1'b0;
      id    = '0;
      idx   = 0;
      for (int unsigned off = NUM_LINES; off > 0; off--) begin
         idx = 32'(rr_ptr) + off - 1;
         if (idx >= NUM_LINES) begin
            idx = idx - NUM_LINES;
         end
         if (pending[idx[ID_W-1:0]]) begin
            valid = 1'b1;
            id    = idx[ID_W-1:0];
         end
      end
   end

endmodule

// File: rtl/irq_dispatch_ctrl.sv
// Round-robin interrupt dispatcher: req/ack to the core, one-cycle clear to the
// event unit, with timeout and withdrawal handling so no line can stall the rest.
module irq_dispatch_ctrl
   import irq_dispatch_pkg::*;
#(
   parameter int unsigned NUM_LINES      = 32,
   parameter int unsigned ID_W           = $clog2(NUM_LINES),
   parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
   parameter int unsigned HOLDOFF_CYCLES = DEFAULT_HOLDOFF_CYCLES
) (
   input  logic                 HCLK,
   input  logic                 HRESETn,
   input  logic [NUM_LINES-1:0] pending_i,
   output logic                 irq_req_o,
   output logic [ID_W-1:0]      irq_id_o,
   input  logic                 irq_ack_i,
   output logic [NUM_LINES-1:0] clear_o,
   output logic                 timeout_o,
   output logic                 busy_o
);

   localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int unsigned HO_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
   localparam logic [TO_W-1:0] TO_LAST =
      TO_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
   localparam logic [HO_W-1:0] HO_LAST =
      HO_W'((HOLDOFF_CYCLES == 0) ? 0 : HOLDOFF_CYCLES - 1);

   dispatch_state_e        state_q, state_d;
   logic [ID_W-1:0]        id_q, id_d;
   logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
   logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
   logic [HO_W-1:0]        ho_cnt_q, ho_cnt_d;
   logic                   req_q, req_d;
   logic [NUM_LINES-1:0]   clear_q, clear_d;
   logic                   timeout_q, timeout_d;
   logic                   busy_q, busy_d;

   logic                   ff_valid;
   logic [ID_W-1:0]        ff_id;
   logic [ID_W-1:0]        next_ptr;
   dispatch_state_e        after_req;

   rr_find_first #(
      .NUM_LINES (NUM_LINES),
      .ID_W      (ID_W)
   ) u_rr_find_first (
      .pending (pending_i),
      .rr_ptr  (rr_ptr_q),
      .valid   (ff_valid),
      .id      (ff_id)
   );

   always_comb begin
      next_ptr  = (32'(id_q) == NUM_LINES - 1) ? '0 : id_q + 1'b1;
      after_req = (HOLDOFF_CYCLES == 0) ? IDLE : HOLDOFF;
   end

   always_comb begin
      state_d   = state_q;
      id_d      = id_q;
      rr_ptr_d  = rr_ptr_q;
      to_cnt_d  = to_cnt_q;
      ho_cnt_d  = ho_cnt_q;
      clear_d   = '0;
      timeout_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (ff_valid) begin
               id_d     = ff_id;
               to_cnt_d = '0;
               state_d  = REQ;
            end
         end
         REQ: begin
            // Exit order: ack beats withdrawal, withdrawal beats timeout.
            if (irq_ack_i) begin
               rr_ptr_d      = next_ptr;
               clear_d[id_q] = 1'b1;
               state_d       = CLEAR;
            end else if (!pending_i[id_q]) begin
               rr_ptr_d = next_ptr;
               ho_cnt_d = '0;
               state_d  = after_req;
            end else if ((TIMEOUT_CYCLES != 0) && (to_cnt_q == TO_LAST)) begin
               rr_ptr_d  = next_ptr;
               timeout_d = 1'b1;
               ho_cnt_d  = '0;
               state_d   = after_req;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
         end
         CLEAR: begin
            ho_cnt_d = '0;
            state_d  = after_req;
         end
         HOLDOFF: begin
            if (ho_cnt_q == HO_LAST) begin
               state_d = IDLE;
            end else begin
               ho_cnt_d = ho_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      req_d  = (state_d == REQ);
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q   <= IDLE;
         id_q      <= '0;
         rr_ptr_q  <= '0;
         to_cnt_q  <= '0;
         ho_cnt_q  <= '0;
         req_q     <= 1'b0;
         clear_q   <= '0;
         timeout_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         id_q      <= id_d;
         rr_ptr_q  <= rr_ptr_d;
         to_cnt_q  <= to_cnt_d;
         ho_cnt_q  <= ho_cnt_d;
         req_q     <= req_d;
         clear_q   <= clear_d;
         timeout_q <= timeout_d;
         busy_q    <= busy_d;
      end
   end

   assign irq_req_o = req_q;
   assign irq_id_o  = id_q;
   assign clear_o   = clear_q;
   assign timeout_o = timeout_q;
   assign busy_o    = busy_q;

endmodule

// File: tb/tb_irq_dispatch_ctrl.sv
// Directed bench for irq_dispatch_ctrl: per-cycle vector table plus hand-written
// timeout, ack/timeout collision and reset sequences.
module tb_irq_dispatch_ctrl;

   logic        HCLK;
   logic        HRESETn;
   logic [31:0] pending_i;
   logic        irq_req_o;
   logic [4:0]  irq_id_o;
   logic        irq_ack_i;
   logic [31:0] clear_o;
   logic        timeout_o;
   logic        busy_o;

   int total;
   int bad;

   typedef struct {
      logic [31:0] pend;
      logic        ack;
      logic        req;
      logic [4:0]  id;
      logic [31:0] clr;
      logic        busy;
   } vec_t;

   vec_t tbl[$];

   irq_dispatch_ctrl #(
      .NUM_LINES      (32),
      .ID_W           (5),
      .TIMEOUT_CYCLES (8),
      .HOLDOFF_CYCLES (2)
   ) dut (
      .HCLK      (HCLK),
      .HRESETn   (HRESETn),
      .pending_i (pending_i),
      .irq_req_o (irq_req_o),
      .irq_id_o  (irq_id_o),
      .irq_ack_i (irq_ack_i),
      .clear_o   (clear_o),
      .timeout_o (timeout_o),
      .busy_o    (busy_o)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic row(input logic [31:0] p, input logic a, input logic r,
                      input logic [4:0] i, input logic [31:0] c, input logic b);
      vec_t v;
      v.pend = p; v.ack = a; v.req = r; v.id = i; v.clr = c; v.busy = b;
      tbl.push_back(v);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_req"},  32'(irq_req_o), 32'd0);
      chk({tag, "_id"},   32'(irq_id_o),  32'd0);
      chk({tag, "_clr"},  clear_o,        32'd0);
      chk({tag, "_tmo"},  32'(timeout_o), 32'd0);
      chk({tag, "_busy"}, 32'(busy_o),    32'd0);
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      HRESETn   = 1'b0;
      pending_i = '0;
      irq_ack_i = 1'b0;

      // columns: pending, ack -> req, id (checked when req), clear, busy
      // single line 4, then ack outside REQ ignored
      row(32'h10, 0, 1, 4, 32'h0,  1);
      row(32'h10, 1, 0, 0, 32'h10, 1);
      row(32'h0,  1, 0, 0, 32'h0,  1);
      row(32'h0,  1, 0, 0, 32'h0,  1);
      row(32'h0,  0, 0, 0, 32'h0,  0);
      row(32'h0,  1, 0, 0, 32'h0,  0);
      // round-robin 0x81 from rr=5: 7, 0, 7, 0
      row(32'h81, 0, 1, 7, 32'h0,  1);
      row(32'h81, 1, 0, 0, 32'h80, 1);
      row(32'h81, 0, 0, 0, 32'h0,  1);
      row(32'h81, 0, 0, 0, 32'h0,  1);
      row(32'h81, 0, 0, 0, 32'h0,  0);
      row(32'h81, 0, 1, 0, 32'h0,  1);
      row(32'h81, 1, 0, 0, 32'h1,  1);
      row(32'h81, 0, 0, 0, 32'h0,  1);
      row(32'h81, 0, 0, 0, 32'h0,  1);
      row(32'h81, 0, 0, 0, 32'h0,  0);
      row(32'h81, 0, 1, 7, 32'h0,  1);
      row(32'h81, 1, 0, 0, 32'h80, 1);
      row(32'h81, 0, 0, 0, 32'h0,  1);
      row(32'h81, 0, 0, 0, 32'h0,  1);
      row(32'h81, 0, 0, 0, 32'h0,  0);
      row(32'h81, 0, 1, 0, 32'h0,  1);
      row(32'h81, 1, 0, 0, 32'h1,  1);
      row(32'h0,  0, 0, 0, 32'h0,  1);
      row(32'h0,  0, 0, 0, 32'h0,  1);
      row(32'h0,  0, 0, 0, 32'h0,  0);
      // serve 30 to park rr at 31, then wrap: 31 then 1
      row(32'h40000000, 0, 1, 30, 32'h0,        1);
      row(32'h40000000, 1, 0, 0,  32'h40000000, 1);
      row(32'h80000002, 0, 0, 0,  32'h0,        1);
      row(32'h80000002, 0, 0, 0,  32'h0,        1);
      row(32'h80000002, 0, 0, 0,  32'h0,        0);
      row(32'h80000002, 0, 1, 31, 32'h0,        1);
      row(32'h80000002, 1, 0, 0,  32'h80000000, 1);
      row(32'h80000002, 0, 0, 0,  32'h0,        1);
      row(32'h80000002, 0, 0, 0,  32'h0,        1);
      row(32'h80000002, 0, 0, 0,  32'h0,        0);
      row(32'h80000002, 0, 1, 1,  32'h0,        1);
      row(32'h80000002, 1, 0, 0,  32'h2,        1);
      row(32'h0,        0, 0, 0,  32'h0,        1);
      row(32'h0,        0, 0, 0,  32'h0,        1);
      row(32'h0,        0, 0, 0,  32'h0,        0);
      // withdrawal of line 3 (rr=2): no clear
      row(32'h8, 0, 1, 3, 32'h0, 1);
      row(32'h0, 0, 0, 0, 32'h0, 1);
      row(32'h0, 0, 0, 0, 32'h0, 1);
      row(32'h0, 0, 0, 0, 32'h0, 0);
      // ack and withdrawal together (rr=4): ack wins
      row(32'h20, 0, 1, 5, 32'h0,  1);
      row(32'h0,  1, 0, 0, 32'h20, 1);
      row(32'h0,  0, 0, 0, 32'h0,  1);
      row(32'h0,  0, 0, 0, 32'h0,  1);
      row(32'h0,  0, 0, 0, 32'h0,  0);

      tick();
      chk_all_zero("reset");
      tick();
      chk_all_zero("reset_hold");
      @(negedge HCLK);
      HRESETn = 1'b1;
      #1;

      foreach (tbl[k]) begin
         pending_i = tbl[k].pend;
         irq_ack_i = tbl[k].ack;
         tick();
         chk($sformatf("v%0d_req", k),  32'(irq_req_o), 32'(tbl[k].req));
         if (tbl[k].req)
            chk($sformatf("v%0d_id", k), 32'(irq_id_o), 32'(tbl[k].id));
         chk($sformatf("v%0d_clr", k),  clear_o,        tbl[k].clr);
         chk($sformatf("v%0d_tmo", k),  32'(timeout_o), 32'd0);
         chk($sformatf("v%0d_busy", k), 32'(busy_o),    32'(tbl[k].busy));
      end
      irq_ack_i = 1'b0;

      // timeout: rr=6, line 2 only, no ack; drop exactly 8 cycles after request rise
      pending_i = 32'h4;
      tick();
      chk("to_rise_req", 32'(irq_req_o), 32'd1);
      chk("to_rise_id",  32'(irq_id_o),  32'd2);
      for (int i = 1; i < 8; i++) begin
         tick();
         chk($sformatf("to_wait%0d_req", i), 32'(irq_req_o), 32'd1);
         chk($sformatf("to_wait%0d_tmo", i), 32'(timeout_o), 32'd0);
      end
      tick();
      chk("to_fire_req", 32'(irq_req_o), 32'd0);
      chk("to_fire_tmo", 32'(timeout_o), 32'd1);
      chk("to_fire_clr", clear_o,        32'd0);
      tick();
      chk("to_after_tmo", 32'(timeout_o), 32'd0);
      chk("to_after_busy", 32'(busy_o),   32'd1);
      tick();
      chk("to_idle_busy", 32'(busy_o), 32'd0);
      tick();
      chk("to_rereq_req", 32'(irq_req_o), 32'd1);
      chk("to_rereq_id",  32'(irq_id_o),  32'd2);

      // ack lands in the same cycle the timeout would fire
      for (int i = 1; i < 8; i++) tick();
      chk("ackto_pre_req", 32'(irq_req_o), 32'd1);
      irq_ack_i = 1'b1;
      tick();
      irq_ack_i = 1'b0;
      chk("ackto_clr", clear_o,        32'h4);
      chk("ackto_tmo", 32'(timeout_o), 32'd0);
      chk("ackto_req", 32'(irq_req_o), 32'd0);
      pending_i = 32'h0;
      tick();
      chk("ackto_clr_once", clear_o, 32'd0);
      tick();
      tick();
      chk("ackto_idle_busy", 32'(busy_o), 32'd0);

      // reset during REQ: rr=3 would pick 4, after reset rr=0 picks 1
      pending_i = 32'h12;
      tick();
      chk("rst_req_id", 32'(irq_id_o), 32'd4);
      #2;
      HRESETn = 1'b0;
      #1;
      chk_all_zero("rst_in_req");
      tick();
      chk_all_zero("rst_in_req_edge");
      @(negedge HCLK);
      HRESETn = 1'b1;
      tick();
      chk("rst_rereq_req", 32'(irq_req_o), 32'd1);
      chk("rst_rereq_id",  32'(irq_id_o),  32'd1);

      // reset during CLEAR: pulse is lost, line re-dispatched from rr=0
      irq_ack_i = 1'b1;
      tick();
      irq_ack_i = 1'b0;
      chk("rst_clr_seen", clear_o, 32'h2);
      HRESETn = 1'b0;
      #1;
      chk_all_zero("rst_in_clear");
      @(negedge HCLK);
      HRESETn = 1'b1;
      tick();
      chk("rst2_rereq_req", 32'(irq_req_o), 32'd1);
      chk("rst2_rereq_id",  32'(irq_id_o),  32'd1);
      irq_ack_i = 1'b1;
      tick();
      irq_ack_i = 1'b0;
      pending_i = 32'h0;
      chk("rst2_clr", clear_o, 32'h2);
      tick();
      tick();
      tick();
      chk("final_busy", 32'(busy_o),    32'd0);
      chk("final_req",  32'(irq_req_o), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
